// File: rtl/parity_channel_pkg.sv
// Shared constants, word type and parity helper for the parity link.
// Used by both the transmit generator and the inline receive checker.
package parity_channel_pkg;

   localparam int DATA_W_DEF     = 9;
   localparam bit PARITY_EVEN    = 1'b0;
   localparam bit PARITY_ODD_SEL = 1'b1;

   typedef logic [DATA_W_DEF:0] word_t;

   // Zero-extension is harmless: extra zeros do not change the XOR reduce.
   function automatic logic parity_of(
      input logic [63:0] v,
      input logic        odd
   );
      return (^v) ^ odd;
   endfunction

endpackage

// File: rtl/parity_channel_tx.sv
// Transmit half: enable-gated wrapping counter with appended parity bit.
// tx_word is combinational from the registered count.
module parity_channel_tx
   import parity_channel_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter bit PARITY_ODD = PARITY_EVEN
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            enable,
   output logic [DATA_W:0] tx_word
);

   logic [DATA_W-1:0] count;

   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   assign tx_word = {parity_of(64'(count), PARITY_ODD), count};

endmodule

// File: rtl/parity_channel.sv
// Self-checking parity link: counter transmitter plus registered receive checker.
// Define PARITY_ERR_COUNT_EN to add a saturating 8-bit parity error counter.
module parity_channel
   import parity_channel_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter bit PARITY_ODD = PARITY_EVEN
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            enable,
   output logic [DATA_W:0] tx_word,
   input  logic [DATA_W:0] rx_word,
   output logic            data_valid,
   output logic [DATA_W:0] data_out
`ifdef PARITY_ERR_COUNT_EN
   ,
   output logic [7:0]      err_count
`endif
);

   logic ok;

   parity_channel_tx #(
      .DATA_W     (DATA_W),
      .PARITY_ODD (PARITY_ODD)
   ) u_tx (
      .clk     (clk),
      .clr     (clr),
      .enable  (enable),
      .tx_word (tx_word)
   );

   assign ok = (parity_of(64'(rx_word), PARITY_ODD) == 1'b0);

   // A failed word drops valid but keeps the last good payload visible.
   always_ff @(posedge clk) begin
      if (clr) begin
         data_valid <= 1'b0;
         data_out   <= '0;
      end else if (ok) begin
         data_valid <= 1'b1;
         data_out   <= rx_word;
      end else begin
         data_valid <= 1'b0;
      end
   end

`ifdef PARITY_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (clr)
         err_count <= '0;
      else if (!ok && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_parity_channel.sv
// Randomised self-checking bench for parity_channel (DATA_W=9, even parity).
// Reference model tracks the count and receiver outputs from parity rules.
module tb_parity_channel;

   localparam int DW      = 9;
   localparam bit PAR_ODD = 1'b0;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          enable = 1'b0;
   logic [DW:0]   tx_word;
   logic [DW:0]   rx_word;
   logic [DW:0]   rx_force = '0;
   logic          loop = 1'b1;
   logic          data_valid;
   logic [DW:0]   data_out;
`ifdef PARITY_ERR_COUNT_EN
   logic [7:0]    err_count;
`endif

   int checks = 0;
   int errors = 0;

   int          m_cnt = 0;
   logic        m_valid = 1'b0;
   logic [DW:0] m_out = '0;
   int          m_err = 0;

   assign rx_word = loop ? tx_word : rx_force;

   parity_channel #(
      .DATA_W     (DW),
      .PARITY_ODD (PAR_ODD)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .enable     (enable),
      .tx_word    (tx_word),
      .rx_word    (rx_word),
      .data_valid (data_valid),
      .data_out   (data_out)
`ifdef PARITY_ERR_COUNT_EN
      ,
      .err_count  (err_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW:0] mk_word(input int c);
      logic [DW:0] w;
      w[DW-1:0] = c[DW-1:0];
      w[DW]     = (($countones(w[DW-1:0]) % 2) == 1) ^ PAR_ODD;
      return w;
   endfunction

   task automatic tick();
      logic [DW:0] rx_m;
      logic        ok;
      rx_m = loop ? mk_word(m_cnt) : rx_force;
      ok   = (($countones(rx_m) % 2) == int'(PAR_ODD));
      @(posedge clk);
      if (clr) begin
         m_cnt   = 0;
         m_valid = 1'b0;
         m_out   = '0;
         m_err   = 0;
      end else begin
         if (enable) m_cnt = (m_cnt + 1) % (1 << DW);
         if (ok) begin
            m_valid = 1'b1;
            m_out   = rx_m;
         end else begin
            m_valid = 1'b0;
            if (m_err < 255) m_err++;
         end
      end
      #1;
      check_eq("tx_word", 32'(tx_word), 32'(mk_word(m_cnt)));
      check_eq("data_valid", 32'(data_valid), 32'(m_valid));
      check_eq("data_out", 32'(data_out), 32'(m_out));
`ifdef PARITY_ERR_COUNT_EN
      check_eq("err_count", 32'(err_count), 32'(m_err));
`endif
   endtask

   initial begin
      // reset
      clr = 1'b1; enable = 1'b0;
      tick(); tick();
      check_eq("rst_tx", 32'(tx_word), 32'h000);
      check_eq("rst_valid", 32'(data_valid), 32'h0);
      check_eq("rst_out", 32'(data_out), 32'h000);
      clr = 1'b0;
      tick();
      check_eq("post_clr_valid", 32'(data_valid), 32'h1);
      check_eq("post_clr_out", 32'(data_out), 32'h000);

      // count steps
      enable = 1'b1;
      tick(); check_eq("step1", 32'(tx_word), 32'h201);
      tick(); check_eq("step2", 32'(tx_word), 32'h202);
      tick(); check_eq("step3", 32'(tx_word), 32'h003);
      enable = 1'b0;
      tick(); check_eq("out_follow", 32'(data_out), 32'h003);

      // hold
      for (int i = 0; i < 5; i++) tick();
      check_eq("hold_tx", 32'(tx_word), 32'h003);
      check_eq("hold_out", 32'(data_out), 32'h003);

      // run to 511 then wrap
      enable = 1'b1;
      for (int i = 0; i < 600 && m_cnt != 511; i++) tick();
      check_eq("max_tx", 32'(tx_word), 32'h3FF);
      tick();
      check_eq("wrap_tx", 32'(tx_word), 32'h000);
      check_eq("wrap_valid", 32'(data_valid), 32'h1);
      enable = 1'b0;
      tick();

      // corrupted channel
      loop = 1'b0; rx_force = 10'h001;
      tick();
      check_eq("bad_valid", 32'(data_valid), 32'h0);
      check_eq("bad_hold", 32'(data_out), 32'h000);
      rx_force = 10'h201;
      tick();
      check_eq("good_valid", 32'(data_valid), 32'h1);
      check_eq("good_out", 32'(data_out), 32'h201);
`ifdef PARITY_ERR_COUNT_EN
      check_eq("err_one", 32'(err_count), 32'h1);
`endif
      loop = 1'b1;

      // clear with enable at count 5
      clr = 1'b1; tick(); clr = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check_eq("cnt5", 32'(tx_word), 32'(mk_word(5)));
      clr = 1'b1;
      tick();
      check_eq("clr_en_tx", 32'(tx_word), 32'h000);
      check_eq("clr_en_valid", 32'(data_valid), 32'h0);
      clr = 1'b0;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         enable   = 1'($urandom % 2);
         clr      = ($urandom % 64) == 0;
         loop     = ($urandom % 4) != 0;
         rx_force = 10'($urandom);
         tick();
      end

      // long error burst to exercise saturation
      clr = 1'b0; loop = 1'b0; rx_force = 10'h001;
      for (int i = 0; i < 300; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
